line_burst_adaptor: RTL and testbench

//  Responder on the cache-side pmem interface (pmem_read/pmem_write/pmem_resp, full 256-bit lines) driven by
//  the cache controllers (I$, D$, prefetch path). Converts each line request into a BEATS-beat burst on the
//  64-bit physical-memory bus and returns a single-cycle resp_o once the whole line has been transferred.

---
 rtl/pmem_pkg.sv | 25 ++
 rtl/line_beat_buf.sv | 41 ++++
 rtl/line_burst_adaptor.sv | 127 ++++++++++++
 tb/tb_line_burst_adaptor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared geometry and state encoding for the cache-line to memory-burst adaptor.
package pmem_pkg;

    localparam int LINE_W   = 256;
    localparam int BURST_W  = 64;
    localparam int ADDR_W   = 32;
    localparam int BEATS    = LINE_W / BURST_W;
    localparam int OFFSET_W = $clog2(LINE_W / 8);
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_W) - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } adaptor_state_t;

    // Clears the byte-within-line bits so every burst starts on a line boundary.
    function automatic logic [ADDR_W-1:0] align_line(input logic [ADDR_W-1:0] addr);
        return addr & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/line_beat_buf.sv
// Line-wide beat buffer: loads a whole line, or one beat at a time, and exposes
// both the selected beat and the full line.
module line_beat_buf
    import pmem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic [LINE_W-1:0]  line_i,
    input  logic               beat_wr_en,
    input  logic [CNT_W-1:0]   beat_idx,
    input  logic [BURST_W-1:0] beat_i,
    output logic [BURST_W-1:0] beat_o,
    output logic [LINE_W-1:0]  line_o
);

    logic [BURST_W-1:0] beat_reg [BEATS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BEATS; i++) begin
                beat_reg[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < BEATS; i++) begin
                beat_reg[i] <= line_i[i*BURST_W +: BURST_W];
            end
        end else if (beat_wr_en) begin
            beat_reg[beat_idx] <= beat_i;
        end
    end

    assign beat_o = beat_reg[beat_idx];

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
            assign line_o[gi*BURST_W +: BURST_W] = beat_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/line_burst_adaptor.sv
// Turns one cache-line read/write-back into a BEATS-beat burst on the memory bus
// and answers the cache with a single resp_o pulse once the line has moved.
module line_burst_adaptor
    import pmem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    adaptor_state_t     state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ADDR_W-1:0]  address_reg;
    logic               read_o_reg;
    logic               write_o_reg;
    logic               resp_o_reg;
    logic [LINE_W-1:0]  line_o_reg;

    logic               buf_load;
    logic               buf_wr;
    logic [BURST_W-1:0] buf_beat;
    logic [LINE_W-1:0]  buf_line;
    logic [LINE_W-1:0]  assembled_line;
    logic               last_beat;

    assign last_beat = resp_i && (cnt_reg == CNT_W'(BEATS - 1));
    assign buf_load  = (state_reg == IDLE) && write_i;
    assign buf_wr    = (state_reg == RD) && resp_i;

    line_beat_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (buf_load),
        .line_i     (line_i),
        .beat_wr_en (buf_wr),
        .beat_idx   (cnt_reg),
        .beat_i     (burst_i),
        .beat_o     (buf_beat),
        .line_o     (buf_line)
    );

    // The final beat is still on burst_i when the line is published, so splice it in here.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_assemble
            assign assembled_line[gi*BURST_W +: BURST_W] =
                (cnt_reg == CNT_W'(gi)) ? burst_i : buf_line[gi*BURST_W +: BURST_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            address_reg <= '0;
            read_o_reg  <= 1'b0;
            write_o_reg <= 1'b0;
            resp_o_reg  <= 1'b0;
            line_o_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (write_i) begin
                        address_reg <= align_line(address_i);
                        write_o_reg <= 1'b1;
                        state_reg   <= WR;
                    end else if (read_i) begin
                        address_reg <= align_line(address_i);
                        read_o_reg  <= 1'b1;
                        state_reg   <= RD;
                    end
                end
                RD: begin
                    if (last_beat) begin
                        cnt_reg    <= '0;
                        read_o_reg <= 1'b0;
                        resp_o_reg <= 1'b1;
                        line_o_reg <= assembled_line;
                        state_reg  <= DONE;
                    end else if (resp_i) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                WR: begin
                    if (last_beat) begin
                        cnt_reg     <= '0;
                        write_o_reg <= 1'b0;
                        resp_o_reg  <= 1'b1;
                        state_reg   <= DONE;
                    end else if (resp_i) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    resp_o_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = line_o_reg;
    assign resp_o    = resp_o_reg;
    assign address_o = address_reg;
    assign read_o    = read_o_reg;
    assign write_o   = write_o_reg;
    assign burst_o   = (state_reg == WR) ? buf_beat : '0;

    // A cache must never raise both requests at once.
    req_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == IDLE) |-> !(read_i && write_i));

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: a cycle table for plain read/write plus
// hand-written gapped, dirty-miss and reset-abort sequences.
module tb_line_burst_adaptor;

    logic         clk;
    logic         rst_n;
    logic         read_i;
    logic         write_i;
    logic [31:0]  address_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int tests = 0;
    int fails = 0;

    line_burst_adaptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .read_i    (read_i),
        .write_i   (write_i),
        .address_i (address_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic         rsp;
        logic [63:0]  bin;
        logic         exp_rd;
        logic         exp_wr;
        logic         exp_resp;
        logic [63:0]  exp_burst;
        logic [31:0]  exp_addr;
        logic         chk_line;
        logic [255:0] exp_line;
    } vec_t;

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;
    localparam logic [255:0] RLINE = {B4, B3, B2, B1};
    localparam logic [255:0] WLINE = {WD, WC, WB, WA};

    vec_t vecs [17];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic rsp, input logic [63:0] bin,
                                input logic erd, input logic ewr, input logic eresp,
                                input logic [63:0] eburst, input logic [31:0] eaddr,
                                input logic chk, input logic [255:0] eline);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.rsp = rsp; v.bin = bin;
        v.exp_rd = erd; v.exp_wr = ewr; v.exp_resp = eresp;
        v.exp_burst = eburst; v.exp_addr = eaddr; v.chk_line = chk; v.exp_line = eline;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read with an arbitrary resp_i pattern; beat k carries seed+k.
    task automatic read_seq(input string tag, input logic [31:0] addr, input logic [15:0] pat,
                            input int plen, input logic [63:0] seed);
        logic [255:0] exp_line;
        int beat = 0;
        int pulses = 0;
        int low_rd = 0;
        for (int k = 0; k < 4; k++) exp_line[k*64 +: 64] = seed + 64'(k);
        @(negedge clk);
        read_i = 1'b1; address_i = addr; resp_i = 1'b0; burst_i = '0;
        for (int i = 0; i < plen; i++) begin
            @(negedge clk);
            if (!read_o) low_rd++;
            if (resp_o) pulses++;
            if (i == 0) check({tag, "_addr"}, 256'(address_o), 256'(addr & 32'hFFFF_FFE0));
            resp_i = pat[i];
            burst_i = pat[i] ? seed + 64'(beat) : 64'hDEAD_BEEF_DEAD_BEEF;
            if (pat[i]) beat++;
        end
        @(negedge clk);
        resp_i = 1'b0; burst_i = '0; read_i = 1'b0;
        check({tag, "_rd_held"}, 256'(low_rd), 256'(0));
        check({tag, "_resp"}, 256'(resp_o), 256'(1));
        check({tag, "_rd_drop"}, 256'(read_o), 256'(0));
        check({tag, "_line"}, line_o, exp_line);
        if (resp_o) pulses++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_o) pulses++;
        end
        check({tag, "_one_resp"}, 256'(pulses), 256'(1));
        $display("[TB] %s read addr=%08h line=%0h", tag, addr, line_o);
    endtask

    initial begin
        int resp_cnt, overlap, wr_cycles, rd_cycles, idle_between, wr_err, wr_idx, rd_beat;
        logic [255:0] dline;
        logic [255:0] dexp;

        rst_n = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0;
        line_i = WLINE; burst_i = '0; resp_i = 1'b0;

        // Plain read with spurious resp_i in DONE and IDLE, then plain write.
        vecs[0]  = mk(1, 0, 32'h1234, 0, 64'h0, 0, 0, 0, 64'h0, 32'h0,    1, 256'h0);
        vecs[1]  = mk(1, 0, 32'h1234, 1, B1,    1, 0, 0, 64'h0, 32'h1220, 0, 256'h0);
        vecs[2]  = mk(1, 0, 32'h1234, 1, B2,    1, 0, 0, 64'h0, 32'h1220, 0, 256'h0);
        vecs[3]  = mk(1, 0, 32'h1234, 1, B3,    1, 0, 0, 64'h0, 32'h1220, 0, 256'h0);
        vecs[4]  = mk(1, 0, 32'h1234, 1, B4,    1, 0, 0, 64'h0, 32'h1220, 0, 256'h0);
        vecs[5]  = mk(1, 0, 32'h1234, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 64'h0, 32'h1220, 1, RLINE);
        vecs[6]  = mk(0, 0, 32'h0,    1, 64'hEEEE_EEEE_EEEE_EEEE, 0, 0, 0, 64'h0, 32'h1220, 1, RLINE);
        vecs[7]  = mk(0, 0, 32'h0,    0, 64'h0, 0, 0, 0, 64'h0, 32'h1220, 1, RLINE);
        vecs[8]  = mk(0, 1, 32'h2345, 0, 64'h0, 0, 0, 0, 64'h0, 32'h1220, 0, 256'h0);
        vecs[9]  = mk(0, 1, 32'h2345, 1, 64'h0, 0, 1, 0, WA,    32'h2340, 0, 256'h0);
        vecs[10] = mk(0, 1, 32'h2345, 1, 64'h0, 0, 1, 0, WB,    32'h2340, 0, 256'h0);
        vecs[11] = mk(0, 1, 32'h2345, 1, 64'h0, 0, 1, 0, WC,    32'h2340, 0, 256'h0);
        vecs[12] = mk(0, 1, 32'h2345, 1, 64'h0, 0, 1, 0, WD,    32'h2340, 0, 256'h0);
        vecs[13] = mk(0, 1, 32'h2345, 0, 64'h0, 0, 0, 1, 64'h0, 32'h2340, 1, RLINE);
        vecs[14] = mk(0, 0, 32'h0,    0, 64'h0, 0, 0, 0, 64'h0, 32'h2340, 1, RLINE);
        vecs[15] = mk(0, 0, 32'h0,    1, 64'h0, 0, 0, 0, 64'h0, 32'h2340, 0, 256'h0);
        vecs[16] = mk(0, 0, 32'h0,    0, 64'h0, 0, 0, 0, 64'h0, 32'h2340, 1, RLINE);

        #1 rst_n = 1'b0;
        #2;
        check("rst_read_o",  256'(read_o),    256'(0));
        check("rst_write_o", 256'(write_o),   256'(0));
        check("rst_resp_o",  256'(resp_o),    256'(0));
        check("rst_addr_o",  256'(address_o), 256'(0));
        check("rst_burst_o", 256'(burst_o),   256'(0));
        check("rst_line_o",  line_o,          256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_read_o", i),  256'(read_o),    256'(vecs[i].exp_rd));
            check($sformatf("vec%0d_write_o", i), 256'(write_o),   256'(vecs[i].exp_wr));
            check($sformatf("vec%0d_resp_o", i),  256'(resp_o),    256'(vecs[i].exp_resp));
            check($sformatf("vec%0d_burst_o", i), 256'(burst_o),   256'(vecs[i].exp_burst));
            check($sformatf("vec%0d_addr_o", i),  256'(address_o), 256'(vecs[i].exp_addr));
            if (vecs[i].chk_line) check($sformatf("vec%0d_line_o", i), line_o, vecs[i].exp_line);
            $display("[TB] vec%0d rd=%0b wr=%0b rsp=%0b -> read_o=%0b write_o=%0b resp_o=%0b burst_o=%0h addr_o=%08h",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].rsp, read_o, write_o, resp_o, burst_o, address_o);
            read_i = vecs[i].rd; write_i = vecs[i].wr; address_i = vecs[i].addr;
            resp_i = vecs[i].rsp; burst_i = vecs[i].bin;
        end
        @(negedge clk);
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0; burst_i = '0;

        // Gapped read: resp_i 1,0,0,1,1,0,1
        read_seq("gap", 32'h0000_ABCD, 16'b101_1001, 7, 64'hC0DE_0000_0000_0000);

        // Dirty miss: write-back held to resp_o, then read requested.
        dline = {64'h0D0D_0000_0000_0003, 64'h0D0D_0000_0000_0002,
                 64'h0D0D_0000_0000_0001, 64'h0D0D_0000_0000_0000};
        for (int k = 0; k < 4; k++) dexp[k*64 +: 64] = 64'h5EED_0000_0000_0000 + 64'(k);
        resp_cnt = 0; overlap = 0; wr_cycles = 0; rd_cycles = 0;
        idle_between = 0; wr_err = 0; wr_idx = 0; rd_beat = 0;
        @(negedge clk);
        write_i = 1'b1; address_i = 32'h0000_9ABF; line_i = dline;
        for (int cyc = 0; cyc < 40 && resp_cnt < 2; cyc++) begin
            @(negedge clk);
            if (read_o && write_o) overlap++;
            if (write_o) begin
                wr_cycles++;
                if (wr_idx > 3 || burst_o !== dline[wr_idx*64 +: 64]) wr_err++;
                wr_idx++;
            end
            if (read_o) rd_cycles++;
            if (resp_cnt == 1 && !read_o && !write_o && !resp_o) idle_between++;
            resp_i = read_o || write_o;
            burst_i = read_o ? 64'h5EED_0000_0000_0000 + 64'(rd_beat) : 64'h0;
            if (read_o) rd_beat++;
            if (resp_o) begin
                resp_cnt++;
                $display("[TB] dirty resp_o #%0d addr_o=%08h line_o=%0h", resp_cnt, address_o, line_o);
                if (resp_cnt == 1) begin
                    write_i = 1'b0; read_i = 1'b1;
                end else begin
                    read_i = 1'b0;
                    check("dirty_line", line_o, dexp);
                end
            end
        end
        resp_i = 1'b0; burst_i = '0; read_i = 1'b0; write_i = 1'b0;
        check("dirty_resp_cnt", 256'(resp_cnt),     256'(2));
        check("dirty_overlap",  256'(overlap),      256'(0));
        check("dirty_wr_cyc",   256'(wr_cycles),    256'(4));
        check("dirty_rd_cyc",   256'(rd_cycles),    256'(4));
        check("dirty_idle",     256'(idle_between), 256'(1));
        check("dirty_wr_beats", 256'(wr_err),       256'(0));
        check("dirty_addr",     256'(address_o),    256'(32'h0000_9AA0));

        // Reset two beats into a read, then a fresh read must start at beat 0.
        @(negedge clk);
        read_i = 1'b1; address_i = 32'h0000_5678;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            resp_i = 1'b1; burst_i = 64'hBAD0_0000_0000_0000 + 64'(b);
        end
        @(negedge clk);
        resp_i = 1'b0; burst_i = '0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_read_o", 256'(read_o),    256'(0));
        check("abort_resp_o", 256'(resp_o),    256'(0));
        check("abort_addr_o", 256'(address_o), 256'(0));
        check("abort_line_o", line_o,          256'(0));
        check("abort_burst",  256'(burst_o),   256'(0));
        $display("[TB] abort read_o=%0b resp_o=%0b addr_o=%08h", read_o, resp_o, address_o);
        read_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        read_seq("post_rst", 32'h0000_7777, 16'b1111, 4, 64'h0F0F_0000_0000_0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
